// File: rtl/dcache_memory_arbiter_if.sv
// Port bundle between the arbiter, the two data cache controllers (LC, SC)
// and the memory controller's load and store channels.
interface dcache_memory_arbiter_if;
    logic        invalidate_i;

    logic        lc_ld_request_i;
    logic        sc_ld_request_i;
    logic [31:0] lc_ld_address_i;
    logic [31:0] sc_ld_address_i;
    logic        lc_st_request_i;
    logic        sc_st_request_i;
    logic [31:0] lc_st_address_i;
    logic [31:0] sc_st_address_i;
    logic [31:0] lc_st_data_i;
    logic [31:0] sc_st_data_i;
    logic [1:0]  lc_st_width_i;
    logic [1:0]  sc_st_width_i;
    logic        lc_lock_i;
    logic        sc_lock_i;

    logic        lc_grant_o;
    logic        sc_grant_o;
    logic [31:0] lc_ld_data_o;
    logic [31:0] sc_ld_data_o;
    logic        lc_ld_valid_o;
    logic        sc_ld_valid_o;
    logic        lc_st_done_o;
    logic        sc_st_done_o;

    logic        mem_ld_request_o;
    logic [31:0] mem_ld_address_o;
    logic        mem_ld_invalidate_o;
    logic [31:0] mem_ld_data_i;
    logic        mem_ld_valid_i;
    logic        mem_st_request_o;
    logic [31:0] mem_st_address_o;
    logic [31:0] mem_st_data_o;
    logic [1:0]  mem_st_width_o;
    logic        mem_st_done_i;

    logic        protocol_error_o;

    // Arbiter side
    modport master (
        input  invalidate_i,
        input  lc_ld_request_i, sc_ld_request_i, lc_ld_address_i, sc_ld_address_i,
        input  lc_st_request_i, sc_st_request_i, lc_st_address_i, sc_st_address_i,
        input  lc_st_data_i, sc_st_data_i, lc_st_width_i, sc_st_width_i,
        input  lc_lock_i, sc_lock_i,
        output lc_grant_o, sc_grant_o, lc_ld_data_o, sc_ld_data_o,
        output lc_ld_valid_o, sc_ld_valid_o, lc_st_done_o, sc_st_done_o,
        output mem_ld_request_o, mem_ld_address_o, mem_ld_invalidate_o,
        input  mem_ld_data_i, mem_ld_valid_i,
        output mem_st_request_o, mem_st_address_o, mem_st_data_o, mem_st_width_o,
        input  mem_st_done_i,
        output protocol_error_o
    );

    // Environment side (controllers plus memory controller)
    modport slave (
        output invalidate_i,
        output lc_ld_request_i, sc_ld_request_i, lc_ld_address_i, sc_ld_address_i,
        output lc_st_request_i, sc_st_request_i, lc_st_address_i, sc_st_address_i,
        output lc_st_data_i, sc_st_data_i, lc_st_width_i, sc_st_width_i,
        output lc_lock_i, sc_lock_i,
        input  lc_grant_o, sc_grant_o, lc_ld_data_o, sc_ld_data_o,
        input  lc_ld_valid_o, sc_ld_valid_o, lc_st_done_o, sc_st_done_o,
        input  mem_ld_request_o, mem_ld_address_o, mem_ld_invalidate_o,
        output mem_ld_data_i, mem_ld_valid_i,
        input  mem_st_request_o, mem_st_address_o, mem_st_data_o, mem_st_width_o,
        output mem_st_done_i,
        input  protocol_error_o
    );
endinterface

// File: rtl/dcache_memory_arbiter.sv
// Round-robin arbiter sharing the memory load/store channels between the cache
// load and store controllers, with burst locking and in-order ID routing FIFOs.
module dcache_memory_arbiter #(
    parameter int MAX_OUTSTANDING = 8
) (
    input logic                    clk_i,
    input logic                    rst_i,
    dcache_memory_arbiter_if.master bus
);
    localparam int PTR_W = $clog2(MAX_OUTSTANDING);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(MAX_OUTSTANDING);
    localparam logic LC_ID = 1'b0;
    localparam logic SC_ID = 1'b1;

    typedef enum logic [1:0] {IDLE, LC_OWNED, SC_OWNED} state_t;

    state_t state, state_next;
    logic   last_grant;

    logic [MAX_OUTSTANDING-1:0] ld_ids, st_ids;
    logic [PTR_W-1:0] ld_wr_ptr, ld_rd_ptr, st_wr_ptr, st_rd_ptr;
    logic [CNT_W-1:0] ld_count, st_count;
    logic             error;

    logic ld_room, st_room, lc_eligible, sc_eligible;
    logic grant_lc, grant_sc, any_grant, grant_id;
    logic sel_ld_request;
    logic [31:0] sel_ld_address, sel_st_address, sel_st_data;
    logic [1:0]  sel_st_width;
    logic ld_push, st_push, ld_response, st_response;
    logic ld_empty, st_empty, ld_pop, st_pop, ld_head, st_head, error_set;

    // A requester with both requests presents only its load; the store waits.
    assign ld_room     = (ld_count != FULL) && !bus.invalidate_i;
    assign st_room     = (st_count != FULL);
    assign lc_eligible = !rst_i && (bus.lc_ld_request_i ? ld_room : (bus.lc_st_request_i && st_room));
    assign sc_eligible = !rst_i && (bus.sc_ld_request_i ? ld_room : (bus.sc_st_request_i && st_room));

    always_comb begin
        grant_lc   = 1'b0;
        grant_sc   = 1'b0;
        state_next = state;
        case (state)
            LC_OWNED: grant_lc = lc_eligible;
            SC_OWNED: grant_sc = sc_eligible;
            default: begin
                if (lc_eligible && sc_eligible) begin
                    grant_lc = (last_grant == SC_ID);
                    grant_sc = (last_grant == LC_ID);
                end else begin
                    grant_lc = lc_eligible;
                    grant_sc = sc_eligible;
                end
            end
        endcase
        case (state)
            IDLE: begin
                if (grant_lc && bus.lc_lock_i)
                    state_next = LC_OWNED;
                else if (grant_sc && bus.sc_lock_i)
                    state_next = SC_OWNED;
            end
            LC_OWNED: if (!bus.lc_lock_i) state_next = IDLE;
            SC_OWNED: if (!bus.sc_lock_i) state_next = IDLE;
            default:  state_next = IDLE;
        endcase
        if (bus.invalidate_i)
            state_next = IDLE;
    end

    assign any_grant      = grant_lc | grant_sc;
    assign grant_id       = grant_sc ? SC_ID : LC_ID;
    assign sel_ld_request = grant_sc ? bus.sc_ld_request_i : bus.lc_ld_request_i;
    assign sel_ld_address = grant_sc ? bus.sc_ld_address_i : bus.lc_ld_address_i;
    assign sel_st_address = grant_sc ? bus.sc_st_address_i : bus.lc_st_address_i;
    assign sel_st_data    = grant_sc ? bus.sc_st_data_i    : bus.lc_st_data_i;
    assign sel_st_width   = grant_sc ? bus.sc_st_width_i   : bus.lc_st_width_i;
    assign ld_push        = any_grant & sel_ld_request;
    assign st_push        = any_grant & ~sel_ld_request;

    assign bus.lc_grant_o          = grant_lc;
    assign bus.sc_grant_o          = grant_sc;
    assign bus.mem_ld_request_o    = ld_push;
    assign bus.mem_ld_address_o    = ld_push ? sel_ld_address : '0;
    assign bus.mem_ld_invalidate_o = bus.invalidate_i;
    assign bus.mem_st_request_o    = st_push;
    assign bus.mem_st_address_o    = st_push ? sel_st_address : '0;
    assign bus.mem_st_data_o       = st_push ? sel_st_data : '0;
    assign bus.mem_st_width_o      = st_push ? sel_st_width : '0;

    // Load data arriving while the pipeline is flushed belongs to a dropped load.
    assign ld_response = bus.mem_ld_valid_i & ~bus.invalidate_i & ~rst_i;
    assign st_response = bus.mem_st_done_i & ~rst_i;
    assign ld_empty    = (ld_count == '0);
    assign st_empty    = (st_count == '0);
    assign ld_pop      = ld_response & ~ld_empty;
    assign st_pop      = st_response & ~st_empty;
    assign ld_head     = ld_ids[ld_rd_ptr];
    assign st_head     = st_ids[st_rd_ptr];
    assign error_set   = (ld_response & ld_empty) | (st_response & st_empty);

    assign bus.lc_ld_valid_o    = ld_pop & (ld_head == LC_ID);
    assign bus.sc_ld_valid_o    = ld_pop & (ld_head == SC_ID);
    assign bus.lc_ld_data_o     = bus.lc_ld_valid_o ? bus.mem_ld_data_i : '0;
    assign bus.sc_ld_data_o     = bus.sc_ld_valid_o ? bus.mem_ld_data_i : '0;
    assign bus.lc_st_done_o     = st_pop & (st_head == LC_ID);
    assign bus.sc_st_done_o     = st_pop & (st_head == SC_ID);
    assign bus.protocol_error_o = error;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= IDLE;
            last_grant <= SC_ID;
            ld_wr_ptr  <= '0;
            ld_rd_ptr  <= '0;
            ld_count   <= '0;
            st_wr_ptr  <= '0;
            st_rd_ptr  <= '0;
            st_count   <= '0;
            error      <= 1'b0;
        end else begin
            state <= state_next;
            if (any_grant)
                last_grant <= grant_id;
            if (ld_push) begin
                ld_ids[ld_wr_ptr] <= grant_id;
                ld_wr_ptr         <= ld_wr_ptr + PTR_W'(1);
            end
            if (ld_pop)
                ld_rd_ptr <= ld_rd_ptr + PTR_W'(1);
            ld_count <= ld_count + CNT_W'(ld_push) - CNT_W'(ld_pop);
            if (bus.invalidate_i) begin
                ld_wr_ptr <= '0;
                ld_rd_ptr <= '0;
                ld_count  <= '0;
            end
            if (st_push) begin
                st_ids[st_wr_ptr] <= grant_id;
                st_wr_ptr         <= st_wr_ptr + PTR_W'(1);
            end
            if (st_pop)
                st_rd_ptr <= st_rd_ptr + PTR_W'(1);
            st_count <= st_count + CNT_W'(st_push) - CNT_W'(st_pop);
            if (error_set)
                error <= 1'b1;
        end
    end
endmodule
